axum_host_arb: RTL



---
 rtl/axum_host_arb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/axum_host_arb.sv
// axum_host_arb: shares one bus host port between NrHosts OBI requesters and routes
// in-order responses back by host ID. Define AXUM_ARB_FIXED_PRIO_EN for fixed priority (host 0 wins).
module axum_host_arb #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrHosts-1:0]              host_req_i,
  output logic [NrHosts-1:0]              host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
  input  logic [NrHosts-1:0]              host_we_i,
  input  logic [NrHosts*4-1:0]            host_be_i,
  input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]              host_rvalid_o,
  output logic [DataWidth-1:0]            host_rdata_o,
  output logic [NrHosts-1:0]              host_err_o,
  output logic                            bus_req_o,
  input  logic                            bus_gnt_i,
  output logic [AddressWidth-1:0]         bus_addr_o,
  output logic                            bus_we_o,
  output logic [3:0]                      bus_be_o,
  output logic [DataWidth-1:0]            bus_wdata_o,
  input  logic                            bus_rvalid_i,
  input  logic [DataWidth-1:0]            bus_rdata_i,
  input  logic                            bus_err_i,
  output logic                            unexp_rsp_o
);

  localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {ARB_IDLE, ARB_WAIT} state_e;

  state_e         state_q;
  logic [IdW-1:0] sel_q;
  logic [IdW-1:0] sel;
  logic           found;
  logic [IdW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic           unexp_q;
  logic           can_issue, push, pop;
  logic [IdW-1:0] head;
`ifndef AXUM_ARB_FIXED_PRIO_EN
  logic [IdW-1:0] rr_ptr_q;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // No bypass: a pop this cycle does not free a slot until the next one.
  assign can_issue = (count_q < CntW'(MaxOutstanding));

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = sel_q;
    if (state_q == ARB_WAIT) begin
      found = 1'b1;
    end else if (can_issue) begin
      for (int k = 0; k < NrHosts; k++) begin
`ifdef AXUM_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (int'(rr_ptr_q) + k) % NrHosts;
`endif
        if (!found && host_req_i[idx]) begin
          found = 1'b1;
          sel   = IdW'(idx);
        end
      end
    end
  end

  assign push = found & bus_gnt_i;
  assign pop  = bus_rvalid_i & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int i = 0; i < NrHosts; i++) begin
      host_gnt_o[i]    = push && (sel == IdW'(i));
      host_rvalid_o[i] = pop && (head == IdW'(i));
      host_err_o[i]    = pop && bus_err_i && (head == IdW'(i));
    end
  end

  assign bus_req_o    = found;
  assign bus_addr_o   = host_addr_i[int'(sel)*AddressWidth +: AddressWidth];
  assign bus_we_o     = host_we_i[sel];
  assign bus_be_o     = host_be_i[int'(sel)*4 +: 4];
  assign bus_wdata_o  = host_wdata_i[int'(sel)*DataWidth +: DataWidth];
  assign host_rdata_o = bus_rdata_i;
  assign unexp_rsp_o  = unexp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      sel_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      unexp_q  <= 1'b0;
`ifndef AXUM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: if (found && !bus_gnt_i) begin
          state_q <= ARB_WAIT;
          sel_q   <= sel;
        end
        ARB_WAIT: if (bus_gnt_i) state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
`ifndef AXUM_ARB_FIXED_PRIO_EN
        rr_ptr_q <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + IdW'(1);
`endif
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (bus_rvalid_i && count_q == '0) unexp_q <= 1'b1;
    end
  end

endmodule
